phase_sig_gen: RTL
==================

# phase_sig_gen

Generates two square waves with programmable period, duty and phase offset, all in `sys_clk` cycles. It is the stimulus source for the phase-difference and frequency measurement path: in self-test, `sig_out0`/`sig_out1` drive the measurement inputs, and a known offset must read back as the same cycle count. A valid/ready config port updates settings, and changes take effect only on a period boundary, so no runt pulses are produced.

## Interface
- `CNT_W`, 32: width of period/high/phase fields and internal counters.
- `DEF_PERIOD`, 100: period applied at reset.
- `DEF_HIGH`, 50: high time applied at reset.
- `DEF_PHASE`, 25: lag of `sig_out1` behind `sig_out0` applied at reset.

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request, level-sensitive.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  config slot free.
- `cfg_period`  in  CNT_W  period P in cycles.
- `cfg_high`  in  CNT_W  high time H in cycles.
- `cfg_phase`  in  CNT_W  lag D of `sig_out1` in cycles.
- `sig_out0`  out  1  reference wave.
- `sig_out1`  out  1  lagged wave.
- `period_start`  out  1  one-cycle pulse at the first cycle of each `sig_out0` period.
- `cfg_err`  out  1  one-cycle pulse when a config is rejected.

## Operation
- **Active config registers (P, H, D):** loaded with the DEF_* values on reset. The pending register is empty on reset.
- **Config validity:** P ≥ 2, 1 ≤ H ≤ P−1, D ≤ P−1.
- **Handshake:** a transfer occurs when `cfg_valid && cfg_ready`.
  - A valid word is captured into the pending register and `cfg_ready` drops.
  - An invalid word is consumed: `cfg_err` pulses the next cycle, pending stays empty, `cfg_ready` stays 1.
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `cnt0` = 0, outputs 0.
  - A pending config is applied on the cycle after capture.
  - `enable` = 1 → RUN.
- **RUN:**
  - `cnt0` counts 0..P−1 and wraps.
  - `cnt1` = (`cnt0` ≥ D) ? `cnt0`−D : `cnt0`+P−D. Use a CNT_W+1-bit intermediate; no overflow is allowed.
  - `sig_out0` = (`cnt0` < H); `sig_out1` = (`cnt1` < H). Both are registered and aligned with the counter value of that cycle.
  - At `cnt0` = P−1: any pending config becomes active, and the next cycle is `cnt0` = 0 under the new P/H/D.
  - `enable` = 0 → DRAIN.
- **DRAIN:**
  - Same counting as RUN.
  - At `cnt0` = P−1, go to IDLE (outputs 0 from the next cycle).
  - If `enable` returns to 1 before the wrap, go back to RUN and do not stop.
- **`cfg_ready`:** returns to 1 on the cycle after pending is applied.
- **Simultaneous events:**
  - A capture in the same cycle as an apply boundary waits for the next boundary.
  - A wrap with `enable` = 0 in DRAIN applies pending, then goes to IDLE.
- **`rst` mid-operation:** immediately forces IDLE, counters 0, all outputs 0, `cfg_ready` 1, DEF_* active, and drops pending.

## Timing
- **Reset values:**
  - `sig_out0` = 0, `sig_out1` = 0, `period_start` = 0, `cfg_err` = 0.
  - `cfg_ready` = 1 (one cycle after `rst` releases, the block accepts a config).
- **Start:** `enable` sampled 1 in IDLE at cycle N.
  - At cycle N+1: `cnt0` = 0, `sig_out0` = 1, `period_start` = 1.
  - `sig_out1` = 1 at N+1 if D = 0, otherwise at N+1+D.
- **Waveform:**
  - `sig_out0` is high for exactly H cycles and low for P−H cycles.
  - `sig_out1` is the same waveform delayed by exactly D cycles, modulo P.
  - The first partial `sig_out1` period after start is high if `cnt1` < H.
- **Config latency:**
  - Capture to active: 1 cycle in IDLE.
  - In RUN: ≤ P_old cycles, taking effect on the first cycle of the next period.
- **`cfg_err` latency:** 1 cycle after the rejected transfer.

## Test plan
- **Reset defaults:** `rst` released, `enable` = 1 → `sig_out0` period 100, high 50; `sig_out1` rising edge 25 cycles after each `sig_out0` rising edge; `period_start` every 100 cycles.
- **Zero and maximum lag:** config P = 10, H = 3, D = 0 → edges coincide. Then config D = 9 → `sig_out1` rises 9 cycles after `sig_out0`, and the change appears only after the `cnt0` = 9 boundary.
- **Mid-period reconfiguration:** offer P = 20, H = 10, D = 5 while `cnt0` = 4 of P = 100 → `cfg_ready` low until the wrap; the next period is exactly 20 cycles; no pulse shorter than H.
- **Invalid configs:** P = 1; H = 0; H = P; D = P → each pulses `cfg_err` once, `cfg_ready` stays 1, output waveform unchanged.
- **Enable drop:** deassert `enable` at `cnt0` = 30 (P = 100) → outputs continue to `cnt0` = 99, then both 0. Reassert at `cnt0` = 60 instead → no interruption.
- **Async reset mid-run:** assert `rst` while `sig_out0` is high → outputs 0 immediately. After release with `enable` = 1 → the default waveform restarts from `cnt0` = 0.

Source files
------------

// File: rtl/phase_sig_gen_if.sv
// Config channel for phase_sig_gen: one valid/ready word of period, high time
// and phase lag.
interface phase_sig_gen_if #(
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_high,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_high,
    input  cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/phase_sig_gen.sv
// Dual square-wave source with programmable period, high time and lag.
// New settings only take effect on a period boundary, so no runt pulses.
module phase_sig_gen #(
  parameter int          CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = 100,
  parameter int unsigned DEF_HIGH   = 50,
  parameter int unsigned DEF_PHASE  = 25
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            enable,
  phase_sig_gen_if.slave  cfg,
  output logic            sig_out0,
  output logic            sig_out1,
  output logic            period_start,
  output logic            cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_PHASE);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] phs_q, phs_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pper_q, pper_d;
  logic [CNT_W-1:0] phigh_q, phigh_d;
  logic [CNT_W-1:0] pphs_q, pphs_d;
  logic             sig0_q, sig0_d;
  logic             sig1_q, sig1_d;
  logic             ps_q, ps_d;
  logic             err_q, err_d;

  logic             cfg_ok;
  logic             xfer;
  logic             wrap;
  logic             apply;
  logic             run_d;
  logic [CNT_W:0]   cnt1_d;

  always_comb begin
    state_d = state_q;
    cnt0_d  = '0;
    per_d   = per_q;
    high_d  = high_q;
    phs_d   = phs_q;
    pend_d  = pend_q;
    pper_d  = pper_q;
    phigh_d = phigh_q;
    pphs_d  = pphs_q;
    cnt1_d  = '0;

    cfg_ok = (cfg.cfg_period >= TWO) &&
             (cfg.cfg_high != '0) &&
             (cfg.cfg_high < cfg.cfg_period) &&
             (cfg.cfg_phase < cfg.cfg_period);
    xfer   = cfg.cfg_valid && !pend_q;
    wrap   = (state_q != IDLE) && (cnt0_q == per_q - ONE);
    apply  = pend_q && ((state_q == IDLE) || wrap);
    err_d  = xfer && !cfg_ok;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (wrap) begin
          state_d = enable ? RUN : IDLE;
        end else begin
          cnt0_d  = cnt0_q + ONE;
          state_d = enable ? RUN : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (apply) begin
      per_d  = pper_q;
      high_d = phigh_q;
      phs_d  = pphs_q;
      pend_d = 1'b0;
    end

    // Pending is always empty when a capture happens, so it never races apply.
    if (xfer && cfg_ok) begin
      pend_d  = 1'b1;
      pper_d  = cfg.cfg_period;
      phigh_d = cfg.cfg_high;
      pphs_d  = cfg.cfg_phase;
    end

    run_d = (state_d != IDLE);

    if (cnt0_d >= phs_d)
      cnt1_d = {1'b0, cnt0_d} - {1'b0, phs_d};
    else
      cnt1_d = {1'b0, cnt0_d} + {1'b0, per_d} - {1'b0, phs_d};

    sig0_d = run_d && (cnt0_d < high_d);
    sig1_d = run_d && (cnt1_d < {1'b0, high_d});
    ps_d   = run_d && (cnt0_d == '0);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt0_q  <= '0;
      per_q   <= DEF_P;
      high_q  <= DEF_H;
      phs_q   <= DEF_D;
      pend_q  <= 1'b0;
      pper_q  <= '0;
      phigh_q <= '0;
      pphs_q  <= '0;
      sig0_q  <= 1'b0;
      sig1_q  <= 1'b0;
      ps_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      per_q   <= per_d;
      high_q  <= high_d;
      phs_q   <= phs_d;
      pend_q  <= pend_d;
      pper_q  <= pper_d;
      phigh_q <= phigh_d;
      pphs_q  <= pphs_d;
      sig0_q  <= sig0_d;
      sig1_q  <= sig1_d;
      ps_q    <= ps_d;
      err_q   <= err_d;
    end
  end

  assign cfg.cfg_ready = ~pend_q;
  assign sig_out0      = sig0_q;
  assign sig_out1      = sig1_q;
  assign period_start  = ps_q;
  assign cfg_err       = err_q;

endmodule
